// File: rtl/fb_arbiter.sv
// Frame-buffer port arbiter: scanout reads (2-cycle latency) win, then the clear engine, then writers round-robin.
// Writers are stalled through combinational wr_ready; the clear engine exists only with FB_CLEAR_EN defined.
module fb_arbiter #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int NUM_WR = 2,
  parameter int ADDR_W = 19
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 scan_req,
  input  logic [9:0]           scan_x,
  input  logic [9:0]           scan_y,
  output logic [2:0]           scan_pixel,
  output logic                 scan_pixel_valid,
  input  logic [NUM_WR-1:0]    wr_valid,
  input  logic [NUM_WR*10-1:0] wr_x,
  input  logic [NUM_WR*10-1:0] wr_y,
  input  logic [NUM_WR*3-1:0]  wr_color,
  output logic [NUM_WR-1:0]    wr_ready,
  input  logic                 clear_start,
  input  logic [2:0]           clear_color,
  output logic                 clear_busy,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic                 mem_we,
  output logic [2:0]           mem_wdata,
  input  logic [2:0]           mem_rdata
);
  localparam int PW    = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;
  localparam int TOTAL = H_RES * V_RES;

  function automatic logic in_range(input logic [9:0] x, input logic [9:0] y);
    return (int'(x) < H_RES) && (int'(y) < V_RES);
  endfunction

  function automatic logic [ADDR_W-1:0] pix_addr(input logic [9:0] x, input logic [9:0] y);
    logic [31:0] a;
    a = 32'(y) * 32'(H_RES) + 32'(x);
    return a[ADDR_W-1:0];
  endfunction

  logic              clearing;
  logic [ADDR_W-1:0] clr_cnt;
  logic [2:0]        clr_color;
  logic [PW-1:0]     rr_ptr;
  logic [PW-1:0]     grant_idx;
  logic              grant_any;
  logic              s1_vld;
  logic              s1_inr;
  logic [ADDR_W-1:0] addr_hold;
  logic [9:0]        gx;
  logic [9:0]        gy;
  logic [2:0]        gc;
  int                idx;

  always_comb begin
    wr_ready  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    mem_addr  = addr_hold;
    grant_any = 1'b0;
    grant_idx = '0;
    gx        = '0;
    gy        = '0;
    gc        = '0;
    idx       = 0;
    if (scan_req) begin
      // Off-screen scan leaves the address untouched; stage 2 substitutes black.
      if (in_range(scan_x, scan_y)) mem_addr = pix_addr(scan_x, scan_y);
    end else if (clearing) begin
      mem_we    = 1'b1;
      mem_addr  = clr_cnt;
      mem_wdata = clr_color;
    end else begin
      for (int k = 0; k < NUM_WR; k++) begin
        idx = (int'(rr_ptr) + k) % NUM_WR;
        if (!grant_any && wr_valid[idx]) begin
          grant_any = 1'b1;
          grant_idx = PW'(idx);
        end
      end
      if (grant_any) begin
        wr_ready[grant_idx] = 1'b1;
        gx        = wr_x[int'(grant_idx)*10 +: 10];
        gy        = wr_y[int'(grant_idx)*10 +: 10];
        gc        = wr_color[int'(grant_idx)*3 +: 3];
        mem_addr  = pix_addr(gx, gy);
        mem_we    = in_range(gx, gy);
        mem_wdata = gc;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr           <= '0;
      s1_vld           <= 1'b0;
      s1_inr           <= 1'b0;
      scan_pixel       <= '0;
      scan_pixel_valid <= 1'b0;
      addr_hold        <= '0;
    end else begin
      addr_hold        <= mem_addr;
      s1_vld           <= scan_req;
      s1_inr           <= scan_req && in_range(scan_x, scan_y);
      scan_pixel_valid <= s1_vld;
      if (s1_vld) scan_pixel <= s1_inr ? mem_rdata : 3'd0;
      if (grant_any) rr_ptr <= (int'(grant_idx) == NUM_WR - 1) ? '0 : grant_idx + 1'b1;
    end
  end

`ifdef FB_CLEAR_EN
  typedef enum logic {IDLE, CLEAR} clr_state_t;
  clr_state_t clr_state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clr_state <= IDLE;
      clr_cnt   <= '0;
      clr_color <= '0;
    end else begin
      case (clr_state)
        IDLE: if (clear_start) begin
          clr_state <= CLEAR;
          clr_cnt   <= '0;
          clr_color <= clear_color;
        end
        CLEAR: if (!scan_req) begin
          if (clr_cnt == ADDR_W'(TOTAL - 1)) clr_state <= IDLE;
          else clr_cnt <= clr_cnt + 1'b1;
        end
      endcase
    end
  end

  assign clearing = (clr_state == CLEAR);
`else
  logic unused_clr;
  assign unused_clr = ^{clear_start, clear_color};
  assign clearing   = 1'b0;
  assign clr_cnt    = '0;
  assign clr_color  = '0;
`endif

  assign clear_busy = clearing;
endmodule

// File: tb/tb_fb_arbiter.sv
// Self-checking bench for fb_arbiter: directed vectors, a reference model checked every cycle, plus literal pins.
module tb_fb_arbiter;
  logic        clock = 1'b0;
  logic        reset;
  logic        scan_req;
  logic [9:0]  scan_x, scan_y;
  logic [2:0]  scan_pixel;
  logic        scan_pixel_valid;
  logic [1:0]  wr_valid;
  logic [19:0] wr_x, wr_y;
  logic [5:0]  wr_color;
  logic [1:0]  wr_ready;
  logic        clear_start;
  logic [2:0]  clear_color;
  logic        clear_busy;
  logic [18:0] mem_addr;
  logic        mem_we;
  logic [2:0]  mem_wdata;
  logic [2:0]  mem_rdata;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  fb_arbiter #(.H_RES(640), .V_RES(480), .NUM_WR(2), .ADDR_W(19)) dut (
    .clock(clock), .reset(reset), .scan_req(scan_req), .scan_x(scan_x), .scan_y(scan_y),
    .scan_pixel(scan_pixel), .scan_pixel_valid(scan_pixel_valid), .wr_valid(wr_valid),
    .wr_x(wr_x), .wr_y(wr_y), .wr_color(wr_color), .wr_ready(wr_ready),
    .clear_start(clear_start), .clear_color(clear_color), .clear_busy(clear_busy),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Synchronous single-port RAM attached to the arbiter.
  logic [2:0] ram [0:(1<<19)-1];
  always @(posedge clock) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s @%0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_wr(input int i, input bit v, input int x, input int y, input int c);
    wr_valid[i]       = v;
    wr_x[i*10 +: 10]  = 10'(x);
    wr_y[i*10 +: 10]  = 10'(y);
    wr_color[i*3 +: 3] = 3'(c);
  endtask

  // Reference model: frame contents, pending scan results and round-robin position.
  typedef struct { int due; int val; } pend_t;
  pend_t      pend[$];
  int         mdl_mem [int];
  bit         chk_en = 1'b0;
  int         cyc = 0;
  int         mptr = 0;
  int         last_px = 0;
  int         last_addr = 0;
  bit         addr_known = 1'b0;

  function automatic int mdl_rd(input int a);
    return mdl_mem.exists(a) ? mdl_mem[a] : 0;
  endfunction

  always @(negedge clock) begin : cmp
    int  exp_rdy, exp_we, exp_wd, g, best, d, wx, wy, wc, sx, sy;
    bit  exp_v;
    if (chk_en) begin
      cyc++;
      exp_v = (pend.size() > 0) && (pend[0].due == cyc);
      if (exp_v) begin
        last_px = pend[0].val;
        void'(pend.pop_front());
      end
      chk("m_scan_valid", int'(scan_pixel_valid), int'(exp_v));
      chk("m_scan_pixel", int'(scan_pixel), last_px);
      chk("m_clear_busy", int'(clear_busy), 0);
      exp_rdy = 0;
      exp_we  = 0;
      exp_wd  = 0;
      g       = -1;
      if (scan_req) begin
        sx = int'(scan_x);
        sy = int'(scan_y);
        if (sx < 640 && sy < 480) begin
          last_addr  = sy * 640 + sx;
          addr_known = 1'b1;
          pend.push_back('{cyc + 2, mdl_rd(last_addr)});
        end else begin
          addr_known = 1'b0;
          pend.push_back('{cyc + 2, 0});
        end
      end else begin
        best = 2;
        for (int i = 0; i < 2; i++) begin
          d = (i - mptr + 2) % 2;
          if (wr_valid[i] && d < best) begin
            best = d;
            g    = i;
          end
        end
        if (g >= 0) begin
          exp_rdy = 1 << g;
          wx = int'(wr_x[g*10 +: 10]);
          wy = int'(wr_y[g*10 +: 10]);
          wc = int'(wr_color[g*3 +: 3]);
          if (wx < 640 && wy < 480) begin
            exp_we     = 1;
            exp_wd     = wc;
            last_addr  = wy * 640 + wx;
            addr_known = 1'b1;
            mdl_mem[last_addr] = wc;
          end else begin
            addr_known = 1'b0;
          end
          mptr = (g + 1) % 2;
        end
      end
      chk("m_wr_ready", int'(wr_ready), exp_rdy);
      chk("m_mem_we", int'(mem_we), exp_we);
      if (addr_known) chk("m_mem_addr", int'(mem_addr), last_addr);
      if (exp_we != 0) chk("m_mem_wdata", int'(mem_wdata), exp_wd);
    end
  end

  int t1_v  [6] = '{0, 0, 1, 1, 1, 0};
  int t1_px [6] = '{0, 0, 3, 5, 6, 6};
  int t3_g  [4] = '{1, 2, 1, 2};

`ifdef FB_CLEAR_EN
  // Small second instance so a complete clear fits in a short run.
  logic        c_rst, c_scan_req, c_pix_vld, c_clear_start, c_clear_busy, c_mem_we;
  logic [2:0]  c_pix, c_clear_color, c_mem_wdata, c_rdata;
  logic [1:0]  c_wr_valid, c_wr_ready;
  logic [19:0] c_wr_x, c_wr_y;
  logic [5:0]  c_wr_color;
  logic [4:0]  c_mem_addr;
  logic [2:0]  c_ram [0:31];

  fb_arbiter #(.H_RES(8), .V_RES(4), .NUM_WR(2), .ADDR_W(5)) u_clr (
    .clock(clock), .reset(c_rst), .scan_req(c_scan_req), .scan_x(10'd0), .scan_y(10'd0),
    .scan_pixel(c_pix), .scan_pixel_valid(c_pix_vld), .wr_valid(c_wr_valid),
    .wr_x(c_wr_x), .wr_y(c_wr_y), .wr_color(c_wr_color), .wr_ready(c_wr_ready),
    .clear_start(c_clear_start), .clear_color(c_clear_color), .clear_busy(c_clear_busy),
    .mem_addr(c_mem_addr), .mem_we(c_mem_we), .mem_wdata(c_mem_wdata), .mem_rdata(c_rdata)
  );

  always @(posedge clock) begin
    if (c_mem_we) c_ram[c_mem_addr] <= c_mem_wdata;
    c_rdata <= c_ram[c_mem_addr];
  end
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, nwr, bad, cnt;
    reset = 1'b1; scan_req = 1'b0; scan_x = '0; scan_y = '0;
    wr_valid = '0; wr_x = '0; wr_y = '0; wr_color = '0;
    clear_start = 1'b0; clear_color = '0;
`ifdef FB_CLEAR_EN
    c_rst = 1'b1; c_scan_req = 1'b0; c_clear_start = 1'b0; c_clear_color = '0;
    c_wr_valid = '0; c_wr_x = {10'd1, 10'd2}; c_wr_y = {10'd1, 10'd1}; c_wr_color = 6'o75;
    for (int a = 0; a < 32; a++) c_ram[a] = '0;
`endif
    for (int a = 0; a < (1 << 19); a++) ram[a] = '0;
    ram[0] = 3'd3; ram[1] = 3'd5; ram[2] = 3'd6;
    mdl_mem[0] = 3; mdl_mem[1] = 5; mdl_mem[2] = 6;

    repeat (2) @(negedge clock);
    chk("rst_pixel", int'(scan_pixel), 0);
    chk("rst_valid", int'(scan_pixel_valid), 0);
    chk("rst_busy", int'(clear_busy), 0);
    chk("rst_ready", int'(wr_ready), 0);
    step();
    reset = 1'b0;
`ifdef FB_CLEAR_EN
    c_rst = 1'b0;
`endif
    chk_en = 1'b1;
    step();

    // Three back-to-back reads of preloaded pixels
    for (int i = 0; i < 6; i++) begin
      scan_req = (i < 3);
      scan_x   = 10'(i);
      scan_y   = '0;
      @(negedge clock);
      chk("t1_valid", int'(scan_pixel_valid), t1_v[i]);
      if (i >= 2) chk("t1_pixel", int'(scan_pixel), t1_px[i]);
      step();
    end

    // Off-screen read returns black with valid
    for (int i = 0; i < 3; i++) begin
      scan_req = (i == 0);
      scan_x   = 10'd700;
      scan_y   = 10'd10;
      @(negedge clock);
      if (i == 0) chk("t2_we", int'(mem_we), 0);
      if (i == 2) begin
        chk("t2_valid", int'(scan_pixel_valid), 1);
        chk("t2_pixel", int'(scan_pixel), 0);
      end
      step();
    end

    // Two writers contending in idle cycles alternate
    set_wr(0, 1'b1, 10, 20, 1);
    set_wr(1, 1'b1, 30, 40, 4);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("t3_grant", int'(wr_ready), t3_g[i]);
      chk("t3_we", int'(mem_we), 1);
      step();
    end
    wr_valid = '0;
    step();
    chk("t3_ram0", int'(ram[20*640+10]), 1);
    chk("t3_ram1", int'(ram[40*640+30]), 4);

    // Writer starved by scanout, then served in the first free cycle
    set_wr(0, 1'b1, 5, 3, 6);
    scan_req = 1'b1; scan_x = 10'd1; scan_y = 10'd1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("t4_starve", int'(wr_ready), 0);
      step();
    end
    scan_req = 1'b0;
    @(negedge clock);
    chk("t4_ready", int'(wr_ready), 1);
    chk("t4_we", int'(mem_we), 1);
    chk("t4_addr", int'(mem_addr), 1925);
    chk("t4_wdata", int'(mem_wdata), 6);
    step();
    wr_valid = '0;
    step();

    // Last pixel of the frame, then an off-screen write that is dropped
    set_wr(1, 1'b1, 639, 479, 7);
    @(negedge clock);
    chk("t5_ready", int'(wr_ready), 2);
    chk("t5_addr", int'(mem_addr), 307199);
    chk("t5_we", int'(mem_we), 1);
    step();
    wr_valid = '0;
    set_wr(0, 1'b1, 640, 0, 5);
    @(negedge clock);
    chk("t5_oob_ready", int'(wr_ready), 1);
    chk("t5_oob_we", int'(mem_we), 0);
    step();
    wr_valid = '0;
    step();
    chk("t5_ram", int'(ram[307199]), 7);

    // Read back the last pixel through scanout
    for (int i = 0; i < 3; i++) begin
      scan_req = (i == 0);
      scan_x   = 10'd639;
      scan_y   = 10'd479;
      @(negedge clock);
      if (i == 2) chk("t6_pixel", int'(scan_pixel), 7);
      step();
    end

`ifndef FB_CLEAR_EN
    // Without the clear engine clear_start must do nothing
    clear_start = 1'b1; clear_color = 3'd2;
    step();
    clear_start = 1'b0;
    set_wr(0, 1'b1, 7, 7, 3);
    @(negedge clock);
    chk("nc_busy", int'(clear_busy), 0);
    chk("nc_ready", int'(wr_ready), 1);
    step();
    wr_valid = '0;
    step();
`else
    // Full clear while scanout takes every other cycle
    c_clear_color = 3'd2; c_clear_start = 1'b1; c_wr_valid = 2'b11;
    step();
    c_clear_start = 1'b0; c_clear_color = 3'd6;
    n = 0; nwr = 0; bad = 0;
    while (c_clear_busy && n < 200) begin
      c_scan_req = (n % 2 == 0);
      @(negedge clock);
      if (c_wr_ready != 2'b00) bad++;
      if (c_mem_we) begin
        if (int'(c_mem_addr) != nwr || c_mem_wdata != 3'd2) bad++;
        nwr++;
      end
      step();
      n++;
    end
    c_scan_req = 1'b0;
    c_wr_valid = '0;
    chk("clr_timeout", int'(n < 200), 1);
    chk("clr_writes", nwr, 32);
    chk("clr_bad", bad, 0);
    chk("clr_busy_end", int'(c_clear_busy), 0);
    cnt = 0;
    for (int a = 0; a < 32; a++) if (c_ram[a] == 3'd2) cnt++;
    chk("clr_ram", cnt, 32);

    // Reset part-way through a clear aborts it immediately
    c_clear_color = 3'd5; c_clear_start = 1'b1;
    step();
    c_clear_start = 1'b0;
    repeat (4) step();
    chk("clr_busy_mid", int'(c_clear_busy), 1);
    c_rst = 1'b1;
    #1;
    chk("clr_rst_abort", int'(c_clear_busy), 0);
    step();
    c_rst = 1'b0;
    step();
`endif

    repeat (3) step();
    chk_en = 1'b0;
    chk("pend_drained", pend.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fb_arbiter.md
Name: fb_arbiter

Overview:
- Shares one single-port synchronous frame buffer RAM between the VGA scanout read path and NUM_WR game-logic pixel writers.
- Scanout reads have absolute priority so the display never misses a pixel. Writers are served round-robin in the remaining cycles, which are mainly blanking.
- Sits between vga_control's pixel fetch and the frame buffer memory. Optionally includes a hardware clear engine.

Parameters:
H_RES, 640, visible pixels per line; also the address stride
V_RES, 480, visible lines
NUM_WR, 2, number of writer ports (1..4)
ADDR_W, 19, RAM address width; must satisfy 2^ADDR_W >= H_RES*V_RES

Ports:
clock  in  1  system/pixel clock
reset  in  1  asynchronous, active-high reset
scan_req  in  1  scanout read request for this cycle
scan_x  in  10  scanout column
scan_y  in  10  scanout row
scan_pixel  out  3  RGB read result
scan_pixel_valid  out  1  scan_pixel holds data for the request issued 2 cycles earlier
wr_valid  in  NUM_WR  per-writer request
wr_x  in  NUM_WR*10  per-writer column, writer i at bits [10i+9:10i]
wr_y  in  NUM_WR*10  per-writer row, same packing as wr_x
wr_color  in  NUM_WR*3  per-writer RGB, writer i at bits [3i+2:3i]
wr_ready  out  NUM_WR  grant; a transfer occurs when wr_valid[i] & wr_ready[i]
clear_start  in  1  pulse to start a full-buffer clear (optional feature)
clear_color  in  3  fill colour, sampled when a clear starts
clear_busy  out  1  clear in progress
mem_addr  out  ADDR_W  RAM address
mem_we  out  1  RAM write enable
mem_wdata  out  3  RAM write data
mem_rdata  in  3  RAM read data, valid 1 cycle after mem_addr with mem_we=0

Behaviour:
- Reset: scan_pixel=0, scan_pixel_valid=0, clear_busy=0, RR pointer=0, read pipeline flags=0, clear FSM=IDLE.
- Reset asserted mid-clear aborts the clear. The buffer keeps whatever was already written.
- mem_addr, mem_we and mem_wdata are combinational from the current-cycle grant.
- wr_ready is combinational and never depends on a writer's own wr_valid beyond arbitration.
- Address calculation: y*H_RES + x, truncated to ADDR_W bits.
- Per-cycle priority:
  1. scan_req
  2. clear engine, when CLEAR
  3. writers, round-robin
- Scan grant:
  - mem_we=0; all wr_ready=0.
  - Stage-1 flag captures the request; stage 2 registers mem_rdata into scan_pixel and raises scan_pixel_valid.
  - Fixed latency: 2 cycles from request to valid. Back-to-back requests give one result per cycle.
  - scan_x>=H_RES or scan_y>=V_RES: no RAM access. Stage 2 returns scan_pixel=0, still with valid.
  - scan_pixel holds its last value while valid=0.
- Writer grant:
  - Candidates are writers with wr_valid=1.
  - Search starts at RR pointer and wraps modulo NUM_WR.
  - Exactly one wr_ready bit is high, for the first candidate found.
  - The granted writer drives mem_we=1, mem_wdata=its colour, mem_addr=its address.
  - After a transfer the RR pointer becomes (granted+1) mod NUM_WR. With no transfer it is unchanged.
- Out-of-range write (x>=H_RES or y>=V_RES): the grant and handshake still complete, but mem_we=0, so the pixel is dropped.
- Writers hold x/y/colour stable while wr_valid=1 and ready=0. Continuous scan_req starves writers; this is by design.
- No request in a cycle: mem_we=0, mem_addr holds its last value.

Optional Feature:
Macro: FB_CLEAR_EN
- Defined:
  - FSM has two states, IDLE and CLEAR.
  - clear_start in IDLE latches clear_color, sets counter=0 and enters CLEAR; clear_busy=1 from the next cycle.
  - In CLEAR, each cycle without scan_req writes the latched colour at the counter address, then increments the counter.
  - Writing address H_RES*V_RES-1 returns the FSM to IDLE; clear_busy falls the following cycle.
  - All wr_ready=0 while in CLEAR.
  - clear_start while busy is ignored.
- Undefined: ports remain; clear_start and clear_color are ignored, and clear_busy is tied to 0.

Test Plan:
- Reset, then 3 back-to-back scan_req at (0,0),(1,0),(2,0) with RAM preloaded 3,5,6 -> scan_pixel_valid high for 3 cycles starting 2 cycles after the first request; scan_pixel=3,5,6.
- scan_req at (700,10) -> no RAM read; 2 cycles later valid=1, scan_pixel=0.
- NUM_WR=2, both wr_valid held high for 4 idle cycles -> grants alternate 0,1,0,1; RAM (x,y) entries contain the written colours.
- wr_valid[0]=1 while scan_req=1 for 5 cycles -> wr_ready[0]=0 throughout; write completes in the first cycle with scan_req=0; mem_addr=y*640+x.
- Write to (639,479) colour 7 -> mem_addr=307199, mem_we=1. Write to (640,0) -> handshake completes with mem_we=0.
- FB_CLEAR_EN: clear_start with colour 2 while scan_req toggles every cycle -> 307200 writes of 2, wr_ready stays 0, clear_busy drops afterwards. Separately, reset mid-clear -> clear_busy=0 immediately.
